// File: rtl/hex_entry_ctrl.sv
// hex_entry_ctrl: front-panel hex keypad entry controller.
// Synchronizes and debounces 16 hex keys plus BACK/ENTER, accumulates an
// N-digit hex value while the CPU is halted, drives the panel display and
// hands committed entries to the control logic over a valid/ready handshake.
module hex_entry_ctrl #(
  parameter int DIGITS          = 6,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stopped,
  input  logic [15:0]           keys,
  input  logic                  key_back,
  input  logic                  key_enter,
  input  logic [4*DIGITS-1:0]   live_value,
  input  logic                  live_valid,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  dispValid,
  output logic [4*DIGITS-1:0]   entry_data,
  output logic                  entry_valid,
  input  logic                  entry_ready
);

  localparam int W   = 4 * DIGITS;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NW  = $clog2(DIGITS + 1);
  localparam logic [4:0] CODE_BACK  = 5'd16;
  localparam logic [4:0] CODE_ENTER = 5'd17;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  // Synchronizer chain: bit 18 = stopped, 17 = enter, 16 = back, 15:0 = hex.
  logic [18:0]     raw;
  logic [18:0]     sync1;
  logic [18:0]     sync2;
  logic [17:0]     keys_s;
  logic            stopped_s;
  logic            stopped_d;

  // Debounce state
  db_state_t       state;
  logic [CW-1:0]   db_cnt;
  logic [17:0]     cur;
  logic [4:0]      cur_code;
  logic            single;
  logic            ev_valid;
  logic [4:0]      ev_code;

  // Entry state
  logic [W-1:0]    entry_buf;
  logic [NW-1:0]   digit_cnt;
  logic            stop_fall;
  logic            ev_apply;

  assign raw       = {stopped, key_enter, key_back, keys};
  assign keys_s    = sync2[17:0];
  assign stopped_s = sync2[18];
  assign stop_fall = stopped_d & ~stopped_s;
  assign ev_apply  = ev_valid & stopped_s & ~entry_valid;

  // Two-flop synchronizers for every asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Exactly one synchronized key active (chords are rejected).
  always_comb begin
    single = (keys_s != '0) && ((keys_s & (keys_s - 18'd1)) == '0);
  end

  // Encode the captured one-hot key into its event code.
  always_comb begin
    cur_code = '0;
    for (int unsigned i = 0; i < 18; i++) begin
      if (cur[i]) cur_code = 5'(i);
    end
  end

  // Debounce FSM: one registered event per stable press, none on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      db_cnt   <= '0;
      cur      <= '0;
      ev_valid <= 1'b0;
      ev_code  <= '0;
    end else begin
      ev_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (single) begin
            state  <= PRESS_WAIT;
            db_cnt <= CW'(1);
            cur    <= keys_s;
          end
        end
        PRESS_WAIT: begin
          if (keys_s == cur) begin
            if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
              ev_valid <= 1'b1;
              ev_code  <= cur_code;
              state    <= HELD;
              db_cnt   <= '0;
            end else begin
              db_cnt <= db_cnt + CW'(1);
            end
          end else begin
            state  <= IDLE;
            db_cnt <= '0;
          end
        end
        HELD: begin
          if (keys_s == '0) begin
            state  <= RELEASE_WAIT;
            db_cnt <= CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (keys_s != '0) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // Entry buffer, digit count and committed-entry handshake.
  // The stopped falling-edge clear takes priority over a same-edge event;
  // the event gate uses pre-edge entry_valid, so an event coinciding with
  // handshake completion is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stopped_d   <= 1'b0;
      entry_buf   <= '0;
      digit_cnt   <= '0;
      entry_data  <= '0;
      entry_valid <= 1'b0;
    end else begin
      stopped_d <= stopped_s;
      if (entry_valid && entry_ready) entry_valid <= 1'b0;
      if (stop_fall) begin
        entry_buf <= '0;
        digit_cnt <= '0;
      end else if (ev_apply) begin
        if (ev_code == CODE_BACK) begin
          entry_buf <= entry_buf >> 4;
          if (digit_cnt != '0) digit_cnt <= digit_cnt - NW'(1);
        end else if (ev_code == CODE_ENTER) begin
          if (digit_cnt != '0) begin
            entry_data  <= entry_buf;
            entry_valid <= 1'b1;
            entry_buf   <= '0;
            digit_cnt   <= '0;
          end
        end else begin
          entry_buf <= {entry_buf[W-5:0], ev_code[3:0]};
          if (digit_cnt != NW'(DIGITS)) digit_cnt <= digit_cnt + NW'(1);
        end
      end
    end
  end

  // Display source: entry buffer while halted, live bus data while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp      <= '0;
      dispValid <= 1'b0;
    end else if (stopped_s) begin
      disp      <= entry_buf;
      dispValid <= 1'b1;
    end else begin
      disp      <= live_value;
      dispValid <= live_valid;
    end
  end

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Directed self-checking bench for hex_entry_ctrl (DIGITS=6, DEBOUNCE_CYCLES=4).
module tb_hex_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stopped;
  logic [15:0] keys;
  logic        key_back;
  logic        key_enter;
  logic [23:0] live_value;
  logic        live_valid;
  logic [23:0] disp;
  logic        dispValid;
  logic [23:0] entry_data;
  logic        entry_valid;
  logic        entry_ready;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int BACK  = 16;
  localparam int ENTER = 17;

  hex_entry_ctrl #(.DIGITS(6), .DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stopped     (stopped),
    .keys        (keys),
    .key_back    (key_back),
    .key_enter   (key_enter),
    .live_value  (live_value),
    .live_valid  (live_valid),
    .disp        (disp),
    .dispValid   (dispValid),
    .entry_data  (entry_data),
    .entry_valid (entry_valid),
    .entry_ready (entry_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_key(input int code, input logic level);
    if (code == BACK) key_back = level;
    else if (code == ENTER) key_enter = level;
    else keys[code] = level;
  endtask

  // Hold a key for 8 edges, release for 8 edges, then park on a falling edge.
  task automatic press(input int code);
    @(negedge clk);
    set_key(code, 1'b1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    set_key(code, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stopped = 1'b1; keys = '0; key_back = 1'b0; key_enter = 1'b0;
    live_value = '0; live_valid = 1'b0; entry_ready = 1'b0;
    #1;
    check("rst_disp", 32'(disp), 32'h0);
    check("rst_dispValid", 32'(dispValid), 32'h0);
    check("rst_entry_valid", 32'(entry_valid), 32'h0);
    check("rst_entry_data", 32'(entry_data), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_dispValid", 32'(dispValid), 32'h1);

    // 1: shift-in with overflow, then BACK
    for (int k = 1; k <= 7; k++) press(k);
    check("t1_disp", 32'(disp), 32'h234567);
    check("t1_cnt", 32'(dut.digit_cnt), 32'd6);
    press(BACK);
    check("t1_back_disp", 32'(disp), 32'h023456);
    check("t1_back_cnt", 32'(dut.digit_cnt), 32'd5);

    // Commit with consumer ready to clear the buffer
    entry_ready = 1'b1;
    press(ENTER);
    check("t1_commit_data", 32'(entry_data), 32'h023456);
    check("t1_commit_valid", 32'(entry_valid), 32'h0);
    check("t1_commit_disp", 32'(disp), 32'h0);
    entry_ready = 1'b0;

    // 2: bouncing key A then a clean hold; then a chord
    for (int b = 0; b < 3; b++) begin
      keys[10] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      keys[10] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
    end
    keys[10] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    keys[10] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t2_bounce_disp", 32'(disp), 32'h00000A);
    check("t2_bounce_cnt", 32'(dut.digit_cnt), 32'd1);
    keys[3] = 1'b1; keys[5] = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    keys[3] = 1'b0; keys[5] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t2_chord_disp", 32'(disp), 32'h00000A);

    // 3: ENTER 0xBEEF with consumer stalled
    press(BACK);
    check("t3_clear_disp", 32'(disp), 32'h0);
    press(11); press(14); press(14); press(15);
    check("t3_typed", 32'(disp), 32'h00BEEF);
    press(ENTER);
    check("t3_valid", 32'(entry_valid), 32'h1);
    check("t3_data", 32'(entry_data), 32'h00BEEF);
    check("t3_disp", 32'(disp), 32'h0);
    press(7);
    check("t3_blocked_disp", 32'(disp), 32'h0);
    check("t3_blocked_data", 32'(entry_data), 32'h00BEEF);
    entry_ready = 1'b1;
    #1;
    check("t3_valid_pre_edge", 32'(entry_valid), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("t3_valid_fall", 32'(entry_valid), 32'h0);
    entry_ready = 1'b0;
    press(7);
    check("t3_after_disp", 32'(disp), 32'h000007);

    // 4: ENTER and BACK on an empty buffer
    press(BACK);
    check("t4_back_to_zero", 32'(disp), 32'h0);
    press(ENTER);
    check("t4_enter_empty", 32'(entry_valid), 32'h0);
    press(BACK);
    check("t4_back_empty_disp", 32'(disp), 32'h0);
    check("t4_back_empty_cnt", 32'(dut.digit_cnt), 32'd0);

    // 5: display source switching
    press(1); press(2);
    check("t5_typed", 32'(disp), 32'h000012);
    live_value = 24'hCAFE01; live_valid = 1'b1;
    stopped = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_disp_2edges", 32'(disp), 32'h000012);
    @(posedge clk);
    @(negedge clk);
    check("t5_disp_live", 32'(disp), 32'hCAFE01);
    check("t5_dispValid_live", 32'(dispValid), 32'h1);
    live_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_dispValid_low", 32'(dispValid), 32'h0);
    press(9);
    stopped = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t5_restop_disp", 32'(disp), 32'h0);
    check("t5_restop_valid", 32'(dispValid), 32'h1);

    // 6: reset mid-debounce with an entry pending
    press(5);
    press(ENTER);
    check("t6_pending", 32'(entry_valid), 32'h1);
    keys[3] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(entry_valid), 32'h0);
    check("t6_rst_data", 32'(entry_data), 32'h0);
    check("t6_rst_disp", 32'(disp), 32'h0);
    check("t6_rst_dispValid", 32'(dispValid), 32'h0);
    @(negedge clk);
    keys[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_no_event", 32'(disp), 32'h0);
    check("t6_no_event_cnt", 32'(dut.digit_cnt), 32'd0);
    press(4);
    check("t6_fresh_press", 32'(disp), 32'h000004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_entry_ctrl.md
# hex_entry_ctrl

Parametrised hex-keypad entry controller for the front-panel UI: it debounces 16 hex keys plus BACK and ENTER, and accumulates an N-digit hex value while the CPU is halted. It drives the panel display with that value, or with live bus data while the CPU runs, and hands each committed entry to the control logic over a valid/ready handshake.

## Interface
- DIGITS, 6: number of hex digits held and displayed; W = 4*DIGITS.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized cycles required to accept a press or a release; minimum 2.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- stopped  in  1  CPU halted; key entry is enabled only while high.
- keys  in  16  raw hex keys, bit i = digit i; asynchronous, active-high.
- key_back  in  1  raw BACK key; asynchronous, active-high.
- key_enter  in  1  raw ENTER key; asynchronous, active-high.
- live_value  in  W  value displayed while running.
- live_valid  in  1  live_value meaningful.
- disp  out  W  registered display value.
- dispValid  out  1  registered display-valid flag.
- entry_data  out  W  committed entry, stable while entry_valid.
- entry_valid  out  1  committed entry pending.
- entry_ready  in  1  consumer accepts entry_data.

## Operation
- All 18 raw keys, plus stopped, pass through 2-flop synchronizers. Everything downstream uses the synchronized copies.
- Debounce FSM states:
  - IDLE: exactly one key active → PRESS_WAIT, counter=1.
  - PRESS_WAIT: the same single key is still active → counter++. When counter reaches DEBOUNCE_CYCLES, emit a one-cycle press event and go to HELD. Any change (release, a different key, or a second key) → IDLE.
  - HELD: all keys released → RELEASE_WAIT, counter=1.
  - RELEASE_WAIT: all keys still released → counter++. When counter reaches DEBOUNCE_CYCLES → IDLE. Any key active → HELD.
- Multi-key chords never produce an event. Holding a key produces exactly one event, with no auto-repeat.
- Entry state is buf (W bits) and cnt (0..DIGITS).
- A press event is applied only when stopped=1 and entry_valid=0; otherwise it is discarded.
  - hex k: buf ← {buf[W-5:0], k}; cnt ← min(cnt+1, DIGITS). The oldest digit shifts out when full.
  - BACK: buf ← buf >> 4; cnt ← max(cnt-1, 0).
  - ENTER: if cnt>0, entry_data ← buf and entry_valid ← 1; buf and cnt clear. ENTER with cnt=0 is ignored.
- Handshake:
  - entry_valid clears on the edge where entry_valid && entry_ready.
  - entry_data does not change while entry_valid=1.
  - entry_ready while entry_valid=0 has no effect.
- Falling edge of synchronized stopped clears buf and cnt. A pending entry_valid is retained until accepted.
- Display:
  - stopped=1: disp ← buf, dispValid ← 1.
  - stopped=0: disp ← live_value, dispValid ← live_valid.
- Reset values: disp=0, dispValid=0, entry_data=0, entry_valid=0, buf=0, cnt=0, debounce FSM=IDLE, counter=0, synchronizers=0.

## Timing
- Key raw high, first sampled at edge E0: the synchronized level is visible after E1, and PRESS_WAIT is entered at E2.
- The press event is asserted in the cycle after edge E1+DEBOUNCE_CYCLES. buf updates at edge E2+DEBOUNCE_CYCLES, and disp reflects it one edge later.
- entry_valid rises on the same edge as the buf clear that follows ENTER.
- Display path latency: live_value → disp is one edge, plus 2 edges of stopped synchronizer when the display source switches.
- Boundary cases:
  - A press event and an entry_valid handshake completing on the same edge: the event is discarded, because the gate uses pre-edge entry_valid.
  - A press event on the same edge as stopped falls: the clear wins.
  - rst_n asserted mid-debounce or mid-handshake: all state returns to reset values immediately, and entry_valid drops without acceptance.
- Minimum press-to-press interval: 2*DEBOUNCE_CYCLES+2 cycles.

## Test plan
Bench settings: DIGITS=6, DEBOUNCE_CYCLES=4, stopped=1 unless stated.
1. Press 1,2,3,4,5,6,7 (each held 8 cycles, released 8 cycles) → disp=0x234567, cnt=6; then BACK → disp=0x023456, cnt=5.
2. Key 0xA bouncing with 3-cycle pulses, then held 10 cycles → exactly one event, disp=0x00000A. Keys 3 and 5 held together 20 cycles → no event, disp unchanged.
3. Enter 0xBEEF, then ENTER with entry_ready=0 → entry_valid=1, entry_data=0x00BEEF, disp=0. A further key 7 press is ignored. Raise entry_ready → entry_valid falls next edge; the following key 7 press gives disp=0x000007.
4. ENTER with cnt=0 → entry_valid stays 0. BACK with cnt=0 → buf stays 0.
5. Type 0x12, then drop stopped with live_value=0xCAFE01, live_valid=1 → disp=0xCAFE01 three edges later. Raise stopped → disp=0, and key presses applied while stopped=0 are lost.
6. Assert rst_n low mid-PRESS_WAIT and with entry_valid=1 → all outputs are 0 immediately, and no event occurs after release of reset until a fresh press completes.
